// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel tick divider, h/v counters, delayed syncs.
// Optional completed-frame counter enabled by FRAME_COUNT_EN.
module vga_timing_gen #(
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int CLK_DIV   = 4,
   parameter int PIPE_DLY  = 1
) (
   input  logic        clk_d,
   input  logic        reset_n,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        video_on,
   output logic        p_tick,
   output logic        hsync,
   output logic        vsync,
   output logic        frame_start,
   output logic [15:0] frame_cnt
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
   localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
   localparam logic [10:0] HS_BEG   = 11'(H_DISPLAY + H_FRONT);
   localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [10:0] VS_BEG   = 11'(V_DISPLAY + V_FRONT);
   localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);
   localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);

   if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 1024");
   end
   if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be 1..16");
   end
   if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_bad_dly
      $error("vga_timing_gen: PIPE_DLY must be 0..4");
   end

   logic       run;
   logic [3:0] div_cnt;
   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic       h_wrap;
   logic       hs_raw;
   logic       vs_raw;

   always_ff @(posedge clk_d or negedge reset_n) begin
      if (!reset_n) begin
         run <= 1'b0;
      end else begin
         run <= 1'b1;
      end
   end

   always_ff @(posedge clk_d or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= 4'd0;
      end else if (run) begin
         div_cnt <= p_tick ? 4'd0 : div_cnt + 4'd1;
      end
   end

   assign p_tick = run && (div_cnt == DIV_LAST);
   assign h_wrap = (h_cnt == H_LAST);

   always_ff @(posedge clk_d or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt <= 10'd0;
         v_cnt <= 10'd0;
      end else if (p_tick) begin
         if (h_wrap) begin
            h_cnt <= 10'd0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
         end else begin
            h_cnt <= h_cnt + 10'd1;
         end
      end
   end

   assign x = h_cnt;
   assign y = v_cnt;

   assign video_on = run
                  && ({1'b0, h_cnt} < H_VIS)
                  && ({1'b0, v_cnt} < V_VIS);

   assign hs_raw = !(({1'b0, h_cnt} >= HS_BEG)
                  && ({1'b0, h_cnt} < HS_END));
   assign vs_raw = !(({1'b0, v_cnt} >= VS_BEG)
                  && ({1'b0, v_cnt} < VS_END));

   assign frame_start = p_tick && h_wrap && (v_cnt == V_LAST);

   // Syncs trail x/y so they line up with the renderers' registered RGB.
   if (PIPE_DLY == 0) begin : g_sync_comb
      assign hsync = hs_raw;
      assign vsync = vs_raw;
   end else begin : g_sync_pipe
      logic [PIPE_DLY-1:0] hs_q;
      logic [PIPE_DLY-1:0] vs_q;
      logic [PIPE_DLY:0]   hs_nx;
      logic [PIPE_DLY:0]   vs_nx;

      assign hs_nx = {hs_q, hs_raw};
      assign vs_nx = {vs_q, vs_raw};

      always_ff @(posedge clk_d or negedge reset_n) begin
         if (!reset_n) begin
            hs_q <= '1;
            vs_q <= '1;
         end else begin
            hs_q <= hs_nx[PIPE_DLY-1:0];
            vs_q <= vs_nx[PIPE_DLY-1:0];
         end
      end

      assign hsync = hs_q[PIPE_DLY-1];
      assign vsync = vs_q[PIPE_DLY-1];
   end

`ifdef FRAME_COUNT_EN
   logic [15:0] fcnt_q;

   always_ff @(posedge clk_d or negedge reset_n) begin
      if (!reset_n) begin
         fcnt_q <= 16'h0000;
      end else if (frame_start) begin
         fcnt_q <= fcnt_q + 16'h0001;
      end
   end

   assign frame_cnt = fcnt_q;
`else
   assign frame_cnt = 16'h0000;
`endif

endmodule
